hmmm_core: RTL and testbench
============================

# hmmm_core

Parametrised multi-cycle successor to the 8-bit two-phase processor: same 4-bit-funct instruction set, generalised in data width, address width and register count. Runs on one edge-triggered clock with a ready-handshaked memory port, so fetch, load and store tolerate any number of wait states. Adds a halt instruction and an optional multiply. Sits at top level between the instruction/data memory and the pad ring.

## Interface
- DATA_W, 8: datapath, register and immediate width.
- ADDR_W, 8: PC and memory address width; must be ≤ DATA_W.
- NREGS, 8: register count, power of two ≥ 4. RA_W = clog2(NREGS). INSTR_W = 4 + RA_W + DATA_W.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  request address.
- mem_wdata  out  DATA_W  store data.
- mem_rdata  in  INSTR_W  read data; loads use [DATA_W-1:0].
- mem_ready  in  1  transfer completes on an edge where mem_req & mem_ready.
- pc  out  ADDR_W  current PC.
- halted  out  1  core stopped.

## Operation
- Instruction fields: funct = [INSTR_W-1 -: 4]; rd = next RA_W bits; imm = [DATA_W-1:0]; rs = imm[DATA_W-1 -: RA_W]; rt = the RA_W bits below rs.
- 0000 halt. 0001 setn rd←imm. 0010 storer mem[R[rt]]←R[rs]. 0011 loadr rd←mem[R[rt]]. 0100 copy rd←R[rt]. 0101 neg rd←0−R[rt]. 0110 add rd←R[rs]+R[rt]. 0111 sub rd←R[rs]−R[rt].
- 1000 jeqzn, 1001 jnezn, 1010 jgtzn, 1011 jltzn: test R[rd] (zero / nonzero / signed >0 / signed <0); if taken PC←imm[ADDR_W-1:0], else PC+1. 1100 jumpn PC←imm. 1110 jumpr PC←R[rd][ADDR_W-1:0]. 1101 see Configuration. 1111 nop.
- Arithmetic modulo 2^DATA_W; carry/overflow discarded. PC increments modulo 2^ADDR_W (wraps to 0).
- States: FETCH, EXEC, MEM, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On handshake latch instruction → EXEC.
  - EXEC: one cycle. Register ops write rd and PC+1 → FETCH. Branches update PC → FETCH. loadr/storer → MEM, PC not yet advanced. halt → HALT, PC unchanged.
  - MEM: mem_req=1, mem_addr=R[rt][ADDR_W-1:0], mem_we=1 and mem_wdata=R[rs] for storer. On handshake: loadr writes rd; PC+1 → FETCH.
  - HALT: mem_req=0, halted=1; left only by reset.
- mem_req, mem_we, mem_addr, mem_wdata are registered-state-derived and held stable until handshake; mem_ready outside a request is ignored.
- Registers write on the rising edge; reads combinational; same register as source and destination reads old value.

## Timing
- Reset value (immediately on reset low): state FETCH, pc=0, all registers 0, mem_req=0 while reset low, mem_we=0, halted=0, mem_addr=0, mem_wdata=0.
- First request on first edge after reset release (mem_req=1, addr 0 in the cycle following deassertion).
- Zero-wait latency: register/branch/halt 2 cycles; loadr/storer 3 cycles. Each wait cycle on mem_ready adds one.
- Reset mid-transfer abandons the transfer; no register or PC update from it.

## Configuration
- HMMM_CORE_MUL_EN defined: 1101 = mul, rd←(R[rs]×R[rt])[DATA_W-1:0], single-cycle in EXEC.
- Undefined: 1101 executes as nop (PC+1, no write); no multiplier synthesised.

## Test plan
- Reset release with mem_ready=1, memory {setn r1,5; setn r2,3; sub r3,r1,r2; halt} → r3=2, halted=1 at cycle 8, pc=3.
- mem_ready low for 3 cycles during fetch of setn r1,0x7F → mem_req/mem_addr held constant, r1=0x7F written 3 cycles later than zero-wait.
- storer r1→[r2] with r1=0xA5, r2=0x10, then loadr r4←[r2] → one write of 0xA5 at address 0x10, r4=0xA5.
- r1=0x80: jltzn r1,0x20 → pc=0x20; jgtzn r1 → not taken, pc+1; pc=0xFF non-branch → wraps to 0x00.
- Reset low during MEM wait of storer → mem_req drops immediately, no write, pc=0, registers 0.
- With HMMM_CORE_MUL_EN, r1=12, r2=21, mul r3 → r3=0xFC; without it, r3 unchanged, pc+1.

Source files
------------

// File: rtl/hmmm_core.sv
// hmmm_core: parametrised multi-cycle HMMM processor with a ready-handshaked memory port.
// Define HMMM_CORE_MUL_EN to make funct 1101 a multiply; otherwise it executes as a nop.
module hmmm_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NREGS  = 8,
  localparam int RA_W    = $clog2(NREGS),
  localparam int INSTR_W = 4 + RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} stateType;

  stateType           state;
  logic [INSTR_W-1:0] instr;
  logic [DATA_W-1:0]  regs [NREGS];

  logic [3:0]        funct;
  logic [RA_W-1:0]   rd, rs, rt;
  logic [DATA_W-1:0] imm, rdVal, rsVal, rtVal, aluRes;
  logic [ADDR_W-1:0] pcInc, pcNext;
  logic              regWrite, toMem, toHalt;

  assign funct = instr[INSTR_W-1 -: 4];
  assign rd    = instr[INSTR_W-5 -: RA_W];
  assign imm   = instr[DATA_W-1:0];
  assign rs    = imm[DATA_W-1 -: RA_W];
  assign rt    = imm[DATA_W-1-RA_W -: RA_W];
  assign rdVal = regs[rd];
  assign rsVal = regs[rs];
  assign rtVal = regs[rt];
  assign pcInc = pc + ADDR_W'(1);

  // Execute-stage decode: result, register write enable and next PC.
  always_comb begin
    aluRes   = '0;
    regWrite = 1'b0;
    toMem    = 1'b0;
    toHalt   = 1'b0;
    pcNext   = pcInc;
    case (funct)
      4'b0000: begin toHalt = 1'b1; pcNext = pc; end
      4'b0001: begin regWrite = 1'b1; aluRes = imm; end
      4'b0010, 4'b0011: begin toMem = 1'b1; pcNext = pc; end
      4'b0100: begin regWrite = 1'b1; aluRes = rtVal; end
      4'b0101: begin regWrite = 1'b1; aluRes = '0 - rtVal; end
      4'b0110: begin regWrite = 1'b1; aluRes = rsVal + rtVal; end
      4'b0111: begin regWrite = 1'b1; aluRes = rsVal - rtVal; end
      4'b1000: if (rdVal == '0) pcNext = imm[ADDR_W-1:0];
      4'b1001: if (rdVal != '0) pcNext = imm[ADDR_W-1:0];
      4'b1010: if (!rdVal[DATA_W-1] && rdVal != '0) pcNext = imm[ADDR_W-1:0];
      4'b1011: if (rdVal[DATA_W-1]) pcNext = imm[ADDR_W-1:0];
      4'b1100: pcNext = imm[ADDR_W-1:0];
      4'b1110: pcNext = rdVal[ADDR_W-1:0];
`ifdef HMMM_CORE_MUL_EN
      4'b1101: begin regWrite = 1'b1; aluRes = rsVal * rtVal; end
`endif
      default: ;
    endcase
  end

  // Main FSM; memory outputs are registered and only change on a state transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= FETCH;
      pc        <= '0;
      instr     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halted    <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end else if (mem_ready) begin
            instr   <= mem_rdata;
            mem_req <= 1'b0;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (regWrite) regs[rd] <= aluRes;
          if (toHalt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (toMem) begin
            mem_req   <= 1'b1;
            mem_we    <= (funct == 4'b0010);
            mem_addr  <= rtVal[ADDR_W-1:0];
            mem_wdata <= rsVal;
            state     <= MEM;
          end else begin
            pc       <= pcNext;
            mem_req  <= 1'b1;
            mem_addr <= pcNext;
            state    <= FETCH;
          end
        end
        MEM: begin
          if (mem_ready) begin
            if (!mem_we) regs[rd] <= mem_rdata[DATA_W-1:0];
            pc       <= pcInc;
            mem_we   <= 1'b0;
            mem_addr <= pcInc;
            state    <= FETCH;
          end
        end
        HALT: ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_hmmm_core.sv
// Directed self-checking bench for hmmm_core: programs in a behavioural memory,
// store traffic checked against a queue of expected writes.
module tb_hmmm_core;

  logic        clk;
  logic        reset;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [7:0]  mem_addr, mem_wdata, pc;
  logic [14:0] mem_rdata;
  logic [14:0] memArr [256];
  logic [15:0] sbQueue [$];
  int          totalChecks = 0;
  int          passedChecks = 0;
  int          failedChecks = 0;

  hmmm_core dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc), .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign mem_rdata = memArr[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    assert (observed === expected) passedChecks++;
    else begin
      failedChecks++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Store handshakes are popped from the scoreboard and applied to memory.
  always @(posedge clk) begin
    if (reset && mem_req && mem_ready && mem_we) begin
      checkOutput("sbWriteExpected", 32'(sbQueue.size() != 0), 32'd1);
      if (sbQueue.size() != 0) checkOutput("sbWrite", {mem_addr, mem_wdata}, sbQueue.pop_front());
      memArr[mem_addr] = {7'b0, mem_wdata};
    end
  end

  function automatic logic [14:0] rr(input logic [3:0] f, input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
    return {f, d, s, t, 2'b00};
  endfunction

  function automatic logic [14:0] ri(input logic [3:0] f, input logic [2:0] d, input logic [7:0] imm);
    return {f, d, imm};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearMem();
    for (int i = 0; i < 256; i++) memArr[i] = '0;
  endtask

  // Hold reset for two edges, release on a falling edge, stop just after the first request edge.
  task automatic applyStimulus(input logic readyInit);
    reset = 1'b0;
    mem_ready = readyInit;
    tick(2);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    checkOutput("firstReq", mem_req, 1'b1);
    checkOutput("firstAddr", mem_addr, 8'h00);
  endtask

  task automatic waitHalted(input int budget);
    for (int n = 0; n < budget && !halted; n++) tick(1);
    checkOutput("haltReached", halted, 1'b1);
  endtask

  logic [7:0] mulExpect;

  initial begin
    reset = 1'b1;
    mem_ready = 1'b1;
    clearMem();
    #3 reset = 1'b0;
    #1;
    checkOutput("rstReq", mem_req, 1'b0);
    checkOutput("rstPc", pc, 8'h00);
    checkOutput("rstHalted", halted, 1'b0);
    checkOutput("rstWe", mem_we, 1'b0);
    checkOutput("rstAddr", mem_addr, 8'h00);
    checkOutput("rstWdata", mem_wdata, 8'h00);

    // setn / sub / halt with exact halt timing
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'd5);
    memArr[1] = ri(4'b0001, 3'd2, 8'd3);
    memArr[2] = rr(4'b0111, 3'd3, 3'd1, 3'd2);
    memArr[3] = ri(4'b0000, 3'd0, 8'h00);
    applyStimulus(1'b1);
    tick(7);
    checkOutput("t1NotYetHalted", halted, 1'b0);
    tick(1);
    checkOutput("t1Halted", halted, 1'b1);
    checkOutput("t1Pc", pc, 8'h03);
    checkOutput("t1R3", dut.regs[3], 8'h02);
    checkOutput("t1ReqLow", mem_req, 1'b0);

    // fetch wait states
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'h7F);
    memArr[1] = ri(4'b0000, 3'd0, 8'h00);
    applyStimulus(1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("t2HoldReq", mem_req, 1'b1);
      checkOutput("t2HoldAddr", mem_addr, 8'h00);
    end
    mem_ready = 1'b1;
    tick(1);
    checkOutput("t2R1Early", dut.regs[1], 8'h00);
    tick(1);
    checkOutput("t2R1", dut.regs[1], 8'h7F);
    waitHalted(20);

    // store then load through the scoreboard
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'hA5);
    memArr[1] = ri(4'b0001, 3'd2, 8'h10);
    memArr[2] = rr(4'b0010, 3'd0, 3'd1, 3'd2);
    memArr[3] = rr(4'b0011, 3'd4, 3'd0, 3'd2);
    memArr[4] = ri(4'b0000, 3'd0, 8'h00);
    sbQueue.push_back({8'h10, 8'hA5});
    applyStimulus(1'b1);
    waitHalted(40);
    checkOutput("t3R4", dut.regs[4], 8'hA5);
    checkOutput("t3Pc", pc, 8'h04);
    checkOutput("t3Drain", sbQueue.size(), 0);

    // branches and PC wrap
    clearMem();
    memArr[8'h00] = ri(4'b0001, 3'd1, 8'h80);
    memArr[8'h01] = ri(4'b1010, 3'd1, 8'h30);
    memArr[8'h02] = ri(4'b1011, 3'd1, 8'h20);
    memArr[8'h20] = ri(4'b1001, 3'd1, 8'h40);
    memArr[8'h40] = ri(4'b1000, 3'd1, 8'h50);
    memArr[8'h41] = ri(4'b1100, 3'd0, 8'hFF);
    memArr[8'hFF] = ri(4'b0001, 3'd5, 8'h11);
    applyStimulus(1'b1);
    tick(2); checkOutput("t4Setn", pc, 8'h01);
    tick(2); checkOutput("t4JgtzNotTaken", pc, 8'h02);
    tick(2); checkOutput("t4JltzTaken", pc, 8'h20);
    tick(2); checkOutput("t4JnezTaken", pc, 8'h40);
    tick(2); checkOutput("t4JeqzNotTaken", pc, 8'h41);
    tick(2); checkOutput("t4Jumpn", pc, 8'hFF);
    tick(2); checkOutput("t4Wrap", pc, 8'h00);
    checkOutput("t4R5", dut.regs[5], 8'h11);

    // reset during the wait of a store
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'hA5);
    memArr[1] = ri(4'b0001, 3'd2, 8'h10);
    memArr[2] = rr(4'b0010, 3'd0, 3'd1, 3'd2);
    memArr[3] = ri(4'b0000, 3'd0, 8'h00);
    applyStimulus(1'b1);
    tick(4);
    checkOutput("t5PcBefore", pc, 8'h02);
    tick(1);
    mem_ready = 1'b0;
    tick(1);
    checkOutput("t5MemReq", mem_req, 1'b1);
    checkOutput("t5MemWe", mem_we, 1'b1);
    checkOutput("t5MemAddr", mem_addr, 8'h10);
    checkOutput("t5MemWdata", mem_wdata, 8'hA5);
    tick(1);
    #2 reset = 1'b0;
    #1;
    checkOutput("t5ReqDrop", mem_req, 1'b0);
    checkOutput("t5Pc", pc, 8'h00);
    checkOutput("t5R1", dut.regs[1], 8'h00);
    checkOutput("t5R2", dut.regs[2], 8'h00);
    mem_ready = 1'b1;
    tick(2);
    checkOutput("t5NoWrite", memArr[8'h10], 15'h0000);

    // multiply (or nop when the multiplier is not built)
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'd12);
    memArr[1] = ri(4'b0001, 3'd2, 8'd21);
    memArr[2] = rr(4'b1101, 3'd3, 3'd1, 3'd2);
    memArr[3] = ri(4'b0000, 3'd0, 8'h00);
`ifdef HMMM_CORE_MUL_EN
    mulExpect = 8'hFC;
`else
    mulExpect = 8'h00;
`endif
    applyStimulus(1'b1);
    waitHalted(30);
    checkOutput("t6R3", dut.regs[3], mulExpect);
    checkOutput("t6Pc", pc, 8'h03);

    // neg / copy / add / jumpr plus a second observed store
    clearMem();
    memArr[0] = ri(4'b0001, 3'd1, 8'd7);
    memArr[1] = rr(4'b0101, 3'd2, 3'd0, 3'd1);
    memArr[2] = rr(4'b0100, 3'd3, 3'd0, 3'd2);
    memArr[3] = rr(4'b0110, 3'd4, 3'd1, 3'd3);
    memArr[4] = ri(4'b0001, 3'd7, 8'h40);
    memArr[5] = rr(4'b0010, 3'd0, 3'd2, 3'd7);
    memArr[6] = ri(4'b0001, 3'd6, 8'h09);
    memArr[7] = ri(4'b1110, 3'd6, 8'h00);
    memArr[8] = ri(4'b0001, 3'd5, 8'hEE);
    memArr[9] = ri(4'b0000, 3'd0, 8'h00);
    sbQueue.push_back({8'h40, 8'hF9});
    applyStimulus(1'b1);
    waitHalted(60);
    checkOutput("t7R2Neg", dut.regs[2], 8'hF9);
    checkOutput("t7R3Copy", dut.regs[3], 8'hF9);
    checkOutput("t7R4Add", dut.regs[4], 8'h00);
    checkOutput("t7R5Skipped", dut.regs[5], 8'h00);
    checkOutput("t7Pc", pc, 8'h09);
    checkOutput("t7Drain", sbQueue.size(), 0);

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
